// File: rtl/round_div_rr_sched.sv
// Round-robin arbiter feeding a two-stage round-half-up divide-by-2^shift unit with saturation.
// Define ROUND_DIV_RR_STATS_EN to add the saturating sat_count output.
module round_div_rr_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHW       = 3,
    parameter int unsigned IN_WIDTH  = OUT_WIDTH + 2**SHW - 1,
    parameter int unsigned IDW       = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SHW-1:0]  req_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [IDW-1:0]          out_id,
`ifdef ROUND_DIV_RR_STATS_EN
    output logic [15:0]             sat_count,
`endif
    output logic                    out_sat
);

    localparam int unsigned TW = OUT_WIDTH + 2**SHW;

    logic [IDW-1:0]      ptr;
    logic                a_valid;
    logic [IN_WIDTH-1:0] a_data;
    logic [SHW-1:0]      a_shift;
    logic [IDW-1:0]      a_id;

    logic                b_adv;
    logic                a_adv;
    logic                gnt_found;
    logic [IDW-1:0]      gnt_idx;
    logic                xfer;
    logic [IDW:0]        scan_sum;
    logic [IDW-1:0]      scan_idx;

    logic [IN_WIDTH-1:0] quo;
    logic                rnd;
    logic [TW-1:0]       sum;
    logic                sat;
    logic [OUT_WIDTH-1:0] res;

    assign b_adv = !out_valid || out_ready;
    assign a_adv = !a_valid || b_adv;
    assign xfer  = a_adv && gnt_found && !reset;

    // Scan from ptr upward with explicit wrap so non-power-of-two NUM_REQ works.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ))
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            scan_idx = scan_sum[IDW-1:0];
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_data  <= '0;
            a_shift <= '0;
            a_id    <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            a_valid <= 1'b1;
            a_data  <= req_data[gnt_idx*IN_WIDTH +: IN_WIDTH];
            a_shift <= req_shift[gnt_idx*SHW +: SHW];
            a_id    <= gnt_idx;
            ptr     <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (b_adv) begin
            a_valid <= 1'b0;
        end
    end

    // Round-half-up: add back the last bit shifted out; sum is wide enough to never wrap.
    always_comb begin
        quo = a_data >> a_shift;
        rnd = (a_shift != '0) && a_data[a_shift - SHW'(1)];
        sum = {1'b0, quo} + TW'(rnd);
        sat = |sum[TW-1:OUT_WIDTH];
        res = sat ? '1 : sum[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
        end else if (b_adv) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_data <= res;
                out_id   <= a_id;
                out_sat  <= sat;
            end
        end
    end

`ifdef ROUND_DIV_RR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (b_adv && a_valid && sat && (sat_count != '1))
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_round_div_rr_sched.sv
// Bench for round_div_rr_sched: queue-based reference model checked every cycle, plus literal spot checks.
module tb_round_div_rr_sched;

    localparam int N   = 4;
    localparam int OW  = 16;
    localparam int SW  = 3;
    localparam int IW  = 23;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IW-1:0]   req_data;
    logic [N*SW-1:0]   req_shift;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [IDW-1:0]    out_id;
    logic              out_sat;
`ifdef ROUND_DIV_RR_STATS_EN
    logic [15:0]       sat_count;
`endif

    round_div_rr_sched #(
        .NUM_REQ  (N),
        .OUT_WIDTH(OW),
        .SHW      (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_shift(req_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id),
`ifdef ROUND_DIV_RR_STATS_EN
        .sat_count(sat_count),
`endif
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: in-flight results in acceptance order, tagged with acceptance edge.
    typedef struct {
        int unsigned     id;
        longint unsigned data;
        bit              sat;
        int unsigned     e;
    } item_t;

    item_t       mq[$];
    int unsigned mptr = 0;
    int unsigned cyc  = 0;
    int unsigned pops = 0;

    function automatic void round_model(input longint unsigned d, input int unsigned s,
                                        output longint unsigned r, output bit st);
        longint unsigned t;
        t  = (d + ((s == 0) ? 64'd0 : (64'd1 << (s - 1)))) >> s;
        st = (t > 64'd65535);
        r  = st ? 64'd65535 : t;
    endfunction

    function automatic int model_grant();
        int idx;
        if (mq.size() >= 2 && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (int'(mptr) + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_valid();
        return (mq.size() > 0) && (mq[0].e + 1 != cyc);
    endfunction

    always @(posedge clk or posedge reset) begin
        int              g;
        bit              v;
        item_t           it;
        longint unsigned r;
        bit              st;
        if (reset) begin
            mq.delete();
            mptr = 0;
        end else begin
            g = model_grant();
            v = model_valid();
            if (v && out_ready) begin
                void'(mq.pop_front());
                pops++;
            end
            if (g >= 0) begin
                round_model(req_data[g*IW +: IW], req_shift[g*SW +: SW], r, st);
                it.id   = g;
                it.data = r;
                it.sat  = st;
                it.e    = cyc;
                mq.push_back(it);
                mptr = (g + 1) % N;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] er;
        if (reset) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_id", out_id, 0);
            check("rst_out_sat", out_sat, 0);
        end else begin
            g  = model_grant();
            er = '0;
            if (g >= 0) er = 4'(1) << g;
            check("req_ready", req_ready, er);
            check("out_valid", out_valid, model_valid());
            if (model_valid()) begin
                check("out_data", out_data, mq[0].data);
                check("out_id", out_id, mq[0].id);
                check("out_sat", out_sat, mq[0].sat);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    task automatic send_one(input int id, input logic [IW-1:0] d, input logic [SW-1:0] s,
                            input logic [OW-1:0] ed, input logic es);
        int n = 0;
        @(posedge clk); #1;
        req_data[id*IW +: IW] = d;
        req_shift[id*SW +: SW] = s;
        req_valid = '0;
        req_valid[id] = 1'b1;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) begin
            timeout_fail("send_accept");
            req_valid = '0;
            return;
        end
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1;
        check("lit_valid", out_valid, 1);
        check("lit_data", out_data, ed);
        check("lit_id", out_id, id);
        check("lit_sat", out_sat, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int unsigned p0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shift = '0;
        #1 reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_data[i*IW +: IW]  = IW'(i * 100 + 7);
            req_shift[i*SW +: SW] = SW'(i);
        end
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // All requesters active: strict rotation starting at 0
        wait_out("rr_first");
        for (int j = 0; j < 8; j++) begin
            check("rr_seq_all", out_id, j % 4);
            @(negedge clk);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        #1 req_valid = 4'b1010;
        do_reset();
        wait_out("rr_sparse_first");
        for (int j = 0; j < 4; j++) begin
            check("rr_seq_sparse", out_id, (j % 2 == 1) ? 3 : 1);
            @(negedge clk);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        send_one(0, 23'd20, 3'd3, 16'd3, 1'b0);
        send_one(0, 23'd19, 3'd3, 16'd2, 1'b0);
        send_one(0, 23'h1234, 3'd0, 16'h1234, 1'b0);
        send_one(0, 23'h7FFFC, 3'd3, 16'hFFFF, 1'b1);
        send_one(0, 23'h7FFF7, 3'd3, 16'hFFFF, 1'b0);
        send_one(0, 23'h10000, 3'd0, 16'hFFFF, 1'b1);
        repeat (3) @(posedge clk);

        // Backpressure: 8 requests from requester 2 with a 5-cycle output stall
        p0 = pops;
        #1 out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk); #1;
                    req_data[2*IW +: IW]  = IW'(k * 1000 + 123);
                    req_shift[2*SW +: SW] = SW'(k % 8);
                    req_valid = 4'b0100;
                    n = 0;
                    @(negedge clk);
                    while (!req_ready[2] && n < 30) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!req_ready[2]) timeout_fail("bp_accept");
                end
                @(posedge clk); #1 req_valid = '0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        n = 0;
        while (mq.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (mq.size() != 0) timeout_fail("bp_drain");
        check("bp_result_count", pops - p0, 8);

        // Reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_data[1*IW +: IW]  = IW'(12345);
        req_shift[1*SW +: SW] = 3'd2;
        req_valid = 4'b0010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_full_valid", out_valid, 1);
        check("mid_full_ready", req_ready, 0);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("mid_rst_async", out_valid, 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_no_stale", out_valid, 0);
        end

`ifdef ROUND_DIV_RR_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) send_one(0, 23'h10000, 3'd0, 16'hFFFF, 1'b1);
        @(negedge clk);
        check("sat_count", sat_count, 3);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/round_div_rr_sched.md
Name: round_div_rr_sched

Overview:
Round-robin scheduler that shares one pipelined rounding-divide-by-power-of-two unit between NUM_REQ requesters.
- Each requester supplies an unsigned dividend and its own shift amount.
- The block arbitrates, computes round-half-up of din / 2^shift with saturation, and returns the result tagged with the requester index.
- Sits between several fixed-point scaling clients and a single downstream consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
OUT_WIDTH, 16, result width
SHW, 3, width of per-request shift field; shift range 0..2^SHW-1
IN_WIDTH, OUT_WIDTH+2**SHW-1, dividend width (derived)
IDW, $clog2(NUM_REQ), width of out_id (derived)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; transfer when valid&ready
req_data  input  NUM_REQ*IN_WIDTH  dividends, requester i at bits [i*IN_WIDTH +: IN_WIDTH]
req_shift  input  NUM_REQ*SHW  shift amounts, requester i at [i*SHW +: SHW]
out_valid  output  1  result valid
out_ready  input  1  downstream accept
out_data  output  OUT_WIDTH  rounded, saturated quotient
out_id  output  IDW  index of the requester that produced out_data
out_sat  output  1  1 when out_data was saturated

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, out_id=0, out_sat=0.
  - Stage-A valid=0; RR pointer=0.
  - req_ready=0 while reset is asserted.
- Pipeline: stage A (capture register) -> stage B (output register = out_* ports).
  - b_adv = !out_valid | out_ready.
  - a_adv = !a_valid | b_adv.
- Arbitration (combinational): grant = first requester with req_valid=1, scanning from ptr upward and wrapping modulo NUM_REQ.
  - req_ready[i] = a_adv & grant[i]; at most one bit set.
  - On a transfer, ptr <= granted index+1 (wraps to 0 after NUM_REQ-1).
  - ptr is unchanged when no transfer occurs.
- Transfer: stage A captures data, shift and id.
  - a_valid <= 1 on a transfer; a_valid <= 0 when b_adv & no transfer.
- Arithmetic, computed on stage A contents and registered into stage B when b_adv & a_valid:
  - s = shift. q = din >> s. r = (s==0) ? 0 : din[s-1]. t = q + r, computed OUT_WIDTH+2**SHW bits wide with no truncation.
  - If t > 2^OUT_WIDTH-1: out_data = all ones, out_sat = 1. Otherwise out_data = t[OUT_WIDTH-1:0], out_sat = 0.
  - Values are unsigned. Remainder exactly 0.5 rounds up.
- out_valid:
  - out_valid <= a_valid when b_adv.
  - While out_valid & !out_ready, out_data, out_id and out_sat are held stable.
- Latency and throughput:
  - A transfer at edge k produces out_valid=1 after edge k+1.
  - Sustained throughput is 1 result per cycle when out_ready=1.
- Backpressure:
  - Both stages full with out_ready=0 -> req_ready=0, no grants, no data loss or duplication.
- Requesters must hold req_valid, req_data and req_shift stable until accepted. Grant depends only on req_valid and ptr.
- A requester deasserting valid before acceptance simply loses its turn; no lock-in.
- Reset asserted mid-operation discards both stages immediately; no result is emitted for in-flight requests.

Optional Feature:
ROUND_DIV_RR_STATS_EN
- Defined:
  - Adds output port sat_count [15:0].
  - sat_count increments by 1 each time a result with out_sat=1 is loaded into stage B.
  - It saturates at 16'hFFFF and is cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (defaults):
- Reset: hold reset with req_valid=4'hF -> out_valid=0, req_ready=0, out_data=0. Deassert -> first grant goes to requester 0.
- Rounding: req0 data=20 shift=3 -> out_data=3, out_id=0, out_sat=0, 2 cycles after accept. Then data=19 shift=3 -> 2. Then data=0x1234 shift=0 -> 0x1234.
- Saturation: shift=3 data=0x7FFFC -> 0xFFFF, out_sat=1 (rounding overflow). Data=0x7FFF7 -> 0xFFFF, out_sat=0. Shift=0 data=0x10000 -> 0xFFFF, out_sat=1.
- Fairness: req_valid=4'hF held, out_ready=1 -> out_id sequence 0,1,2,3,0,1... one per cycle. Then req_valid=4'b1010 -> 1,3,1,3.
- Backpressure: stream 8 requests from req2 with out_ready toggled 0 for 5 cycles -> outputs held stable while stalled; all 8 results appear in order, none dropped or repeated; req_ready=0 while both stages are full.
- Mid-op reset / stats: assert reset with both stages full -> out_valid=0 asynchronously and no stale output after release. With ROUND_DIV_RR_STATS_EN, 3 saturating requests -> sat_count=3.
